// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-requester round-robin arbiter in front of a single-port memory
// Optional word-alignment check enabled by defining MEMORY_ARBITER_ALIGN_CHECK_EN.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ma_valid,
    input  logic                  ma_write,
    input  logic [ADDR_WIDTH-1:0] ma_addr,
    input  logic [31:0]           ma_wdata,
    output logic                  ma_ready,
    output logic [31:0]           ma_rdata,
    output logic                  ma_error,
    input  logic                  mb_valid,
    input  logic                  mb_write,
    input  logic [ADDR_WIDTH-1:0] mb_addr,
    input  logic [31:0]           mb_wdata,
    output logic                  mb_ready,
    output logic [31:0]           mb_rdata,
    output logic                  mb_error,
    output logic [ADDR_WIDTH-1:0] mem_in_addr,
    output logic [31:0]           mem_in_data,
    output logic                  mem_in_valid,
    input  logic                  mem_in_ready,
    output logic [ADDR_WIDTH-1:0] mem_out_addr,
    output logic                  mem_out_valid,
    input  logic                  mem_out_ready,
    input  logic [31:0]           mem_out_data,
    input  logic                  mem_addr_error
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q;
    logic                    prio_q;
    logic                    lat_write_q;
    logic [ADDR_WIDTH-1:0]   lat_addr_q;
    logic [31:0]             lat_wdata_q;
    logic                    err_q;
    logic [31:0]             rdata_a_q, rdata_b_q;

    logic                    req_any;
    logic                    sel;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_wdata;
    logic                    misaligned;
    logic                    mem_ready_sel;

    // 0 selects requester a, 1 selects b; prio_q names the side that wins a tie
    assign req_any   = ma_valid | mb_valid;
    assign sel       = (ma_valid && mb_valid) ? prio_q : mb_valid;
    assign sel_write = sel ? mb_write : ma_write;
    assign sel_addr  = sel ? mb_addr  : ma_addr;
    assign sel_wdata = sel ? mb_wdata : ma_wdata;

`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
    assign misaligned = |sel_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign mem_ready_sel = lat_write_q ? mem_in_ready : mem_out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_in_valid  = 1'b0;
        mem_out_valid = 1'b0;
        ma_ready      = 1'b0;
        mb_ready      = 1'b0;
        ma_error      = 1'b0;
        mb_error      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_in_valid  = lat_write_q;
                mem_out_valid = ~lat_write_q;
                if (mem_ready_sel) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ma_ready = ~grant_q;
                mb_ready = grant_q;
                ma_error = ~grant_q & err_q;
                mb_error = grant_q & err_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched fields only change on a grant, so memory-side outputs stay stable through ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            err_q       <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        grant_q     <= sel;
                        prio_q      <= ~sel;
                        lat_write_q <= sel_write;
                        lat_addr_q  <= sel_addr;
                        lat_wdata_q <= sel_wdata;
                        err_q       <= misaligned;
                    end
                end
                ISSUE: begin
                    if (mem_ready_sel) begin
                        err_q <= mem_addr_error;
                        if (!lat_write_q) begin
                            if (grant_q) begin
                                rdata_b_q <= mem_out_data;
                            end else begin
                                rdata_a_q <= mem_out_data;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_in_addr  = lat_addr_q;
    assign mem_out_addr = lat_addr_q;
    assign mem_in_data  = lat_wdata_q;
    assign ma_rdata     = rdata_a_q;
    assign mb_rdata     = rdata_b_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
// Directed vectors, hand sequences and randomized two-requester traffic against a reference model.
module tb_memory_arbiter;

    localparam logic [31:0] ERR_BASE = 32'h0028_0000;
    localparam int          BIG      = 1 << 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ma_valid = 1'b0, ma_write = 1'b0;
    logic [31:0] ma_addr = '0, ma_wdata = '0;
    logic        mb_valid = 1'b0, mb_write = 1'b0;
    logic [31:0] mb_addr = '0, mb_wdata = '0;
    logic        ma_ready, ma_error, mb_ready, mb_error;
    logic [31:0] ma_rdata, mb_rdata;
    logic [31:0] mem_in_addr, mem_in_data, mem_out_addr;
    logic        mem_in_valid, mem_out_valid;
    logic        mem_in_ready, mem_out_ready, mem_addr_error;
    logic [31:0] mem_out_data = '0;

    int compared = 0;
    int mismatched = 0;

    memory_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .ma_valid(ma_valid), .ma_write(ma_write), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_ready(ma_ready), .ma_rdata(ma_rdata), .ma_error(ma_error),
        .mb_valid(mb_valid), .mb_write(mb_write), .mb_addr(mb_addr), .mb_wdata(mb_wdata),
        .mb_ready(mb_ready), .mb_rdata(mb_rdata), .mb_error(mb_error),
        .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data), .mem_in_valid(mem_in_valid),
        .mem_in_ready(mem_in_ready),
        .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid),
        .mem_out_ready(mem_out_ready), .mem_out_data(mem_out_data),
        .mem_addr_error(mem_addr_error)
    );

    always #5 clk = ~clk;

    // Behavioural memory: ready after a programmable number of valid cycles
    logic [31:0] mem [logic [31:0]];
    int wlat = 1, rlat = 2;
    int wcnt = 0, rcnt = 0;
    int cyc_now = 0;

    assign mem_in_ready   = mem_in_valid && (wcnt >= wlat);
    assign mem_out_ready  = mem_out_valid && (rcnt >= rlat);
    assign mem_addr_error = (mem_in_valid ? mem_in_addr : mem_out_addr) >= ERR_BASE;

    always @(posedge clk) begin
        cyc_now <= cyc_now + 1;
        wcnt <= mem_in_valid ? wcnt + 1 : 0;
        rcnt <= mem_out_valid ? rcnt + 1 : 0;
        if (mem_in_valid && mem_in_ready && !mem_addr_error)
            mem[mem_in_addr] = mem_in_data;
        mem_out_data <= mem.exists(mem_out_addr) ? mem[mem_out_addr] : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("excl_mem_valid", {31'b0, mem_in_valid & mem_out_valid}, 32'h0);
            chk("excl_ready", {31'b0, ma_ready & mb_ready}, 32'h0);
        end
    end

    task automatic drive(input bit p, input bit v, input bit w,
                         input logic [31:0] addr, input logic [31:0] data);
        if (p) begin
            mb_valid = v; mb_write = w; mb_addr = addr; mb_wdata = data;
        end else begin
            ma_valid = v; ma_write = w; ma_addr = addr; ma_wdata = data;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Single transaction; cycle 0 is the cycle the request is first presented
    task automatic txn(input bit p, input bit w, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd, output logic er, output int cyc,
                       output logic [7:0] inm, output logic [7:0] outm, output logic [31:0] seen);
        bit done;
        @(negedge clk);
        drive(p, 1, w, addr, data);
        cyc = 0; inm = '0; outm = '0; done = 0; rd = '0; er = 1'b0; seen = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc < 8) begin
                inm[cyc]  = mem_in_valid;
                outm[cyc] = mem_out_valid;
            end
            if (mem_in_valid) seen = mem_in_addr;
            if (mem_out_valid) seen = mem_out_addr;
            if ((p ? mb_ready : ma_ready) === 1'b1) begin
                rd = p ? mb_rdata : ma_rdata;
                er = p ? mb_error : ma_error;
                done = 1;
            end
        end
        drive(p, 0, 0, 0, 0);
        if (!done) chk("txn_timeout", 32'h0, 32'h1);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_cyc;
    } vec_t;

    // Reference model for randomized traffic
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] last_rd [2];
    int start_c [2];
    int last_served = -1;
    int last_done = 0;

    task automatic rand_req(input bit p, input int n);
        bit w, done;
        logic [31:0] addr, data, exp_rd;
        logic exp_er;
        int k;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w    = $urandom_range(0, 1);
            addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00} + (($urandom_range(0, 7) == 0) ? ERR_BASE : 32'h0);
            data = $urandom;
            drive(p, 1, w, addr, data);
            start_c[p] = cyc_now;
            done = 0; k = 0;
            while (!done && k < 100) begin
                @(negedge clk);
                k++;
                if ((p ? mb_ready : ma_ready) === 1'b1) done = 1;
            end
            if (!done) begin
                chk("rand_timeout", 32'h0, 32'h1);
            end else begin
                exp_er = addr >= ERR_BASE;
                if (w) begin
                    if (!exp_er) model_mem[addr] = data;
                end else begin
                    last_rd[p] = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
                end
                exp_rd = last_rd[p];
                chk(p ? "rand_b_rdata" : "rand_a_rdata", p ? mb_rdata : ma_rdata, exp_rd);
                chk(p ? "rand_b_error" : "rand_a_error", {31'b0, p ? mb_error : ma_error}, {31'b0, exp_er});
                if (last_served == int'(p) && start_c[~p] <= last_done + 1)
                    chk("rand_round_robin", {31'b0, p}, {31'b0, ~p});
                last_served = int'(p);
                last_done = cyc_now;
            end
            drive(p, 0, 0, 0, 0);
            start_c[p] = BIG;
        end
    endtask

    initial begin
        vec_t        vecs [8];
        logic [31:0] rd, seen, hold;
        logic        er;
        int          cyc, first, second;
        logic [7:0]  inm, outm;
        bit          seen_issue, pulse;

        vecs[0] = '{1'b1, 32'h100,    32'h1234_5678, 32'h0,          1'b0, 3};
        vecs[1] = '{1'b0, 32'h100,    32'h0,         32'h1234_5678,  1'b0, 4};
        vecs[2] = '{1'b1, 32'h104,    32'ha5a5_a5a5, 32'h1234_5678,  1'b0, 3};
        vecs[3] = '{1'b0, 32'd36,     32'h0,         32'hefef_efef,  1'b0, 4};
        vecs[4] = '{1'b0, 32'h280000, 32'h0,         32'h0,          1'b1, 4};
        vecs[5] = '{1'b0, 32'h27FFFC, 32'h0,         32'h0,          1'b0, 4};
        vecs[6] = '{1'b1, 32'h280000, 32'hdead_beef, 32'h0,          1'b1, 3};
        vecs[7] = '{1'b0, 32'h104,    32'h0,         32'ha5a5_a5a5,  1'b0, 4};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ma_ready", {31'b0, ma_ready}, 32'h0);
        chk("rst_mb_ready", {31'b0, mb_ready}, 32'h0);
        chk("rst_ma_rdata", ma_rdata, 32'h0);
        chk("rst_mb_rdata", mb_rdata, 32'h0);
        chk("rst_mem_valids", {30'b0, mem_in_valid, mem_out_valid}, 32'h0);
        chk("rst_mem_addr", mem_in_addr, 32'h0);

        txn(0, 1, 32'd36, 32'hefef_efef, rd, er, cyc, inm, outm, seen);
        chk("wr36_cycles", cyc, 3);
        chk("wr36_error", {31'b0, er}, 32'h0);
        chk("wr36_in_valid_cycles", {24'b0, inm}, 32'h06);
        chk("wr36_out_valid_cycles", {24'b0, outm}, 32'h00);
        chk("wr36_rdata_held", rd, 32'h0);

        txn(1, 0, 32'd36, 32'h0, rd, er, cyc, inm, outm, seen);
        chk("rd36_cycles", cyc, 4);
        chk("rd36_rdata", rd, 32'hefef_efef);
        chk("rd36_error", {31'b0, er}, 32'h0);
        chk("rd36_out_valid_cycles", {24'b0, outm}, 32'h0e);
        chk("rd36_in_valid_cycles", {24'b0, inm}, 32'h00);

        for (int i = 0; i < 8; i++) begin
            txn(0, vecs[i].w, vecs[i].addr, vecs[i].wdata, rd, er, cyc, inm, outm, seen);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_error", i), {31'b0, er}, {31'b0, vecs[i].exp_er});
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_addr", i), seen, vecs[i].addr);
        end

        hold = mb_rdata;
        txn(1, 1, 32'd38, 32'h1111_2222, rd, er, cyc, inm, outm, seen);
`ifdef MEMORY_ARBITER_ALIGN_CHECK_EN
        chk("align_cycles", cyc, 1);
        chk("align_error", {31'b0, er}, 32'h1);
        chk("align_no_mem_valid", {24'b0, inm | outm}, 32'h0);
        chk("align_rdata_held", rd, hold);
`else
        chk("noalign_cycles", cyc, 3);
        chk("noalign_error", {31'b0, er}, 32'h0);
        chk("noalign_addr", seen, 32'd38);
        chk("noalign_rdata_held", rd, hold);
`endif

        do_reset();
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            drive(0, 1, 0, 32'd36, 0);
            drive(1, 1, 0, 32'd36, 0);
            first = -1; second = -1;
            for (int k = 0; k < 60 && second < 0; k++) begin
                @(negedge clk);
                if (ma_ready) begin
                    if (first < 0) first = 0; else second = 0;
                    drive(0, 0, 0, 0, 0);
                end
                if (mb_ready) begin
                    if (first < 0) first = 1; else second = 1;
                    drive(1, 0, 0, 0, 0);
                end
            end
            drive(0, 0, 0, 0, 0);
            drive(1, 0, 0, 0, 0);
            chk($sformatf("sim%0d_first", r), first, 0);
            chk($sformatf("sim%0d_second", r), second, 1);
        end

        @(negedge clk);
        drive(1, 1, 0, 32'h100, 0);
        seen_issue = 0;
        for (int k = 0; k < 20 && !seen_issue; k++) begin
            @(negedge clk);
            seen_issue = mem_out_valid;
        end
        chk("rst_mid_reached_issue", {31'b0, seen_issue}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'b0, mem_out_valid}, 32'h0);
        chk("rst_mid_mb_rdata", mb_rdata, 32'h0);
        chk("rst_mid_ma_rdata", ma_rdata, 32'h0);
        drive(1, 0, 0, 0, 0);
        pulse = 0;
        repeat (2) begin
            @(negedge clk);
            pulse |= mb_ready | ma_ready;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            pulse |= mb_ready | ma_ready | mem_out_valid;
        end
        chk("rst_mid_no_pulse", {31'b0, pulse}, 32'h0);
        txn(1, 0, 32'h100, 32'h0, rd, er, cyc, inm, outm, seen);
        chk("rst_after_cycles", cyc, 4);
        chk("rst_after_rdata", rd, 32'h1234_5678);

        do_reset();
        mem.delete();
        last_rd[0] = '0; last_rd[1] = '0;
        start_c[0] = BIG; start_c[1] = BIG;
        wlat = $urandom_range(1, 3);
        rlat = $urandom_range(1, 4);
        @(negedge clk);
        fork
            rand_req(0, 40);
            rand_req(1, 40);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
